des_key_sched_iter: RTL and testbench
=====================================

Name: des_key_sched_iter

Overview:
- Iterative, parametrised DES-family round-key generator: one 48-bit round key per cycle instead of 16 parallel combinational copies.
- Uses true 28-bit circular rotation of C/D and supports encrypt order (K1..Kn) and decrypt order (Kn..K1).
- Adds a ready/valid output handshake with backpressure and optional key parity checking.
- Sits between the key register and the iterative DES round engine; reuses the existing PC1 and PC2 permutation modules.

Parameters:
- ROUNDS, 16: number of round keys generated, range 1..16.
- SHIFT_MASK, 16'h7EFC: bit i-1 set means round i rotates by 2, clear means rotate by 1. The default gives the standard DES 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 schedule. Only bits [ROUNDS-1:0] are used.
- PARITY_CHECK, 1: 1 enables odd-parity check of key_in bytes; 0 ties parity_err to 0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request a new schedule; accepted only in IDLE.
- decrypt  in  1  sampled with start; 1 selects reverse key order.
- key_in  in  64  DES key; key_in[63] is DES bit 1. Sampled with start.
- busy  out  1  high from the cycle after acceptance until return to IDLE.
- key_valid  out  1  key_out/round_idx valid.
- key_ready  in  1  consumer accepts the current key.
- key_out  out  48  current round key, PC2 of the {C,D} register.
- round_idx  out  5  1-based DES round number of key_out.
- done  out  1  one-cycle pulse after the last key is accepted.
- parity_err  out  1  at least one key_in byte had even parity; sticky until the next accepted start.

Behaviour:
- Reset: state IDLE. C, D and the round counter cleared. busy, key_valid, done, parity_err = 0. key_out = PC2(0) = 0. round_idx = 0. Reset asserted mid-schedule aborts immediately; no done pulse is generated.
- States: IDLE and GEN.
- IDLE -> GEN on start. On that edge:
  - C0/D0 = PC1(key_in).
  - Encrypt: {C,D} loaded with each half rotated left by s(1), where s(i) = SHIFT_MASK[i-1] ? 2 : 1; round_idx = 1.
  - Decrypt: {C,D} loaded with each half rotated left by TOT mod 28, where TOT = sum of s(1..ROUNDS), computed at elaboration; round_idx = ROUNDS. With the defaults TOT = 28, so the load equals C0/D0.
  - parity_err loads the check result for key_in.
- GEN:
  - key_valid = 1 and busy = 1 throughout.
  - key_out and round_idx are held stable while key_ready = 0, with no limit on stall length.
  - Transfer occurs on key_valid & key_ready.
  - On a transfer that is not the last: encrypt rotates C and D left by s(round_idx+1) and increments round_idx; decrypt rotates C and D right by s(round_idx) and decrements round_idx. The next key is presented the following cycle, so the zero-stall throughput is 1 key/cycle.
  - On the last transfer (encrypt round_idx == ROUNDS; decrypt round_idx == 1): next state IDLE, done = 1 for exactly the next cycle, busy and key_valid = 0 in that same cycle.
- Latency: first key valid 1 cycle after start is accepted. Last key after ROUNDS cycles with no stalls; done 1 cycle after that.
- start while busy is ignored, with no effect on the in-flight schedule or on parity_err.
- start in the same cycle as done (IDLE) is accepted normally; back-to-back schedules therefore have a 1-cycle gap.
- Rotation is strictly modulo 28: bits shifted out of [27] re-enter at [0]. Zero-fill is forbidden.
- After the IDLE -> GEN transition, decrypt and key_in are ignored until the next accepted start.
- With PARITY_CHECK = 1, a parity error does not stop generation; keys are still produced.

Test Plan:
- Encrypt, key_in = 64'h133457799BBCDFF1, key_ready tied high:
  - key_valid from cycle 1 to cycle 16.
  - round_idx 1 has key_out = 48'h1B02EFFC7072.
  - round_idx 2 has key_out = 48'h79AED9DBC9E5.
  - round_idx 16 has key_out = 48'hCB3D8B0E17F5.
  - done pulses at cycle 17; parity_err = 0.
- Decrypt, same key: the first key has round_idx = 16 and key_out = 48'hCB3D8B0E17F5. The last key has round_idx = 1 and key_out = 48'h1B02EFFC7072. The full sequence is the exact reverse of the encrypt run.
- Backpressure: pseudo-random key_ready with stalls of up to 5 cycles. key_out and round_idx stay stable during stalls, the 16 keys match the reference model, and exactly one done pulse occurs.
- Ignored start: start pulsed with a different key at round 5. The sequence continues unchanged. After done, start with key_in = 64'h0 gives parity_err = 1 and 16 keys are still produced.
- Reset mid-operation: rst asserted asynchronously during round 9 (between clock edges). All outputs go to 0 immediately, with no done pulse. A subsequent start runs a clean schedule from round 1.
- Parameter variant: ROUNDS = 4, SHIFT_MASK = 4'b0011. Encrypt yields 4 keys with rotations 2,2,1,1 and done at cycle 5. Decrypt's first key uses C/D rotated left by 6 and matches encrypt key 4.

Source files
------------

// File: rtl/des_key_sched_iter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : des_key_sched_iter
//  Description : Iterative DES-family round-key generator. Produces one
//                48-bit round key per cycle in encrypt (K1..Kn) or decrypt
//                (Kn..K1) order, with a ready/valid output handshake and
//                optional odd-parity checking of the input key.
//  Revision    : 1.0 - initial release
// ============================================================================
module des_key_sched_iter #(
  parameter int          ROUNDS       = 16,
  parameter logic [15:0] SHIFT_MASK   = 16'h7EFC,
  parameter bit          PARITY_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        decrypt,
  input  logic [63:0] key_in,
  output logic        busy,
  output logic        key_valid,
  input  logic        key_ready,
  output logic [47:0] key_out,
  output logic [4:0]  round_idx,
  output logic        done,
  output logic        parity_err
);

  // PC1 selection table, DES bit numbers (bit 1 = key_in[63]), C half first.
  localparam logic [56*7-1:0] c_PC1_TAB = {
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
    7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
    7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
    7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
    7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
    7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
    7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
    7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
  };

  // PC2 selection table, bit numbers into the 56-bit {C,D} (bit 1 = MSB).
  localparam logic [48*6-1:0] c_PC2_TAB = {
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
    6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
    6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
    6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [56*7-1:0] tab;
    logic [6:0]      e;
    logic [5:0]      pos;
    logic [55:0]     o;
    tab = c_PC1_TAB;
    o   = '0;
    for (int i = 0; i < 56; i++) begin
      e   = tab[391:385];
      pos = 6'(7'd64 - e);
      o   = {o[54:0], k[pos]};
      tab = tab << 7;
    end
    return o;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [48*6-1:0] tab;
    logic [5:0]      e;
    logic [5:0]      pos;
    logic [47:0]     o;
    tab = c_PC2_TAB;
    o   = '0;
    for (int i = 0; i < 48; i++) begin
      e   = tab[287:282];
      pos = 6'd56 - e;
      o   = {o[46:0], cd[pos]};
      tab = tab << 6;
    end
    return o;
  endfunction

  // Circular left rotation of a 28-bit half; right rotation is rotl by 28-n.
  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [4:0] n);
    logic [55:0] t;
    t = {x, x} << n;
    return t[55:28];
  endfunction

  // True when any byte has even parity.
  function automatic logic parity_bad(input logic [63:0] k);
    logic        bad;
    logic [63:0] t;
    bad = 1'b0;
    t   = k;
    for (int i = 0; i < 8; i++) begin
      bad = bad | ~(^t[7:0]);
      t   = t >> 8;
    end
    return bad;
  endfunction

  // Sum of per-round shifts over the active rounds, evaluated at elaboration.
  function automatic int total_shift();
    int          s;
    logic [15:0] m;
    s = 0;
    m = SHIFT_MASK;
    for (int i = 0; i < ROUNDS; i++) begin
      s = s + (m[0] ? 2 : 1);
      m = m >> 1;
    end
    return s;
  endfunction

  localparam int          c_TOT     = total_shift();
  localparam logic [4:0]  c_TOT_MOD = 5'(c_TOT % 28);
  localparam logic [4:0]  c_LAST    = 5'(ROUNDS);
  // Zero-extended mask so any 5-bit round number indexes in range.
  localparam logic [31:0] c_MASK_X  = {16'h0000, SHIFT_MASK};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_GEN  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [27:0] r_c;
  logic [27:0] r_d;
  logic [4:0]  r_round;
  logic        r_dec;
  logic        r_done;
  logic        r_perr;

  logic [55:0] w_pc1;
  logic        w_accept;
  logic        w_xfer;
  logic        w_last;
  logic        w_sh2;
  logic [4:0]  w_amt;
  logic [4:0]  w_load_amt;
  logic        w_perr;

  assign w_pc1      = pc1(key_in);
  assign w_accept   = (r_state == ST_IDLE) && start;
  assign w_xfer     = (r_state == ST_GEN) && key_ready;
  assign w_last     = w_xfer && (r_dec ? (r_round == 5'd1) : (r_round == c_LAST));
  // Encrypt steps by s(round+1); decrypt undoes the step of the current round.
  assign w_sh2      = r_dec ? c_MASK_X[r_round - 5'd1] : c_MASK_X[r_round];
  assign w_amt      = r_dec ? (w_sh2 ? 5'd26 : 5'd27) : (w_sh2 ? 5'd2 : 5'd1);
  assign w_load_amt = decrypt ? c_TOT_MOD : (SHIFT_MASK[0] ? 5'd2 : 5'd1);
  assign w_perr     = PARITY_CHECK ? parity_bad(key_in) : 1'b0;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    key_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_GEN;
        end
      end
      ST_GEN: begin
        busy      = 1'b1;
        key_valid = 1'b1;
        if (w_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // C/D, round counter, direction, parity flag and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c     <= '0;
      r_d     <= '0;
      r_round <= '0;
      r_dec   <= 1'b0;
      r_done  <= 1'b0;
      r_perr  <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_c     <= rotl28(w_pc1[55:28], w_load_amt);
        r_d     <= rotl28(w_pc1[27:0], w_load_amt);
        r_round <= decrypt ? c_LAST : 5'd1;
        r_dec   <= decrypt;
        r_perr  <= w_perr;
      end else if (w_xfer && !w_last) begin
        r_c     <= rotl28(r_c, w_amt);
        r_d     <= rotl28(r_d, w_amt);
        r_round <= r_dec ? (r_round - 5'd1) : (r_round + 5'd1);
      end
    end
  end

  assign key_out    = pc2({r_c, r_d});
  assign round_idx  = r_round;
  assign done       = r_done;
  assign parity_err = r_perr;

endmodule
`default_nettype wire

// File: tb/tb_des_key_sched_iter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_des_key_sched_iter
//  Description : Directed bench for des_key_sched_iter (default and 4-round
//                variant) with an independent round-key reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_des_key_sched_iter;

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;

  localparam int PC1_T [56] = '{
    57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
    63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{
    14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};

  logic        clk = 1'b0;
  logic        rst;
  logic        start, decrypt, key_ready;
  logic [63:0] key_in;
  logic        busy, key_valid, done, parity_err;
  logic [47:0] key_out;
  logic [4:0]  round_idx;

  logic        v_start, v_decrypt, v_key_ready;
  logic [63:0] v_key_in;
  logic        v_busy, v_key_valid, v_done, v_parity_err;
  logic [47:0] v_key_out;
  logic [4:0]  v_round_idx;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  des_key_sched_iter u_dut (
    .clk(clk), .rst(rst), .start(start), .decrypt(decrypt), .key_in(key_in),
    .busy(busy), .key_valid(key_valid), .key_ready(key_ready), .key_out(key_out),
    .round_idx(round_idx), .done(done), .parity_err(parity_err)
  );

  des_key_sched_iter #(.ROUNDS(4), .SHIFT_MASK(16'h0003), .PARITY_CHECK(1'b1)) u_var (
    .clk(clk), .rst(rst), .start(v_start), .decrypt(v_decrypt), .key_in(v_key_in),
    .busy(v_busy), .key_valid(v_key_valid), .key_ready(v_key_ready), .key_out(v_key_out),
    .round_idx(v_round_idx), .done(v_done), .parity_err(v_parity_err)
  );

  // Round key r computed directly from the cumulative rotation of C0/D0.
  function automatic logic [47:0] ref_key(input logic [63:0] k, input int r, input logic [15:0] mask);
    int          tot;
    int          p;
    int          src;
    logic [47:0] res;
    tot = 0;
    res = '0;
    for (int i = 0; i < r; i++) tot += mask[i] ? 2 : 1;
    tot = tot % 28;
    for (int o = 0; o < 48; o++) begin
      p = PC2_T[o];
      if (p <= 28) src = PC1_T[(p - 1 + tot) % 28];
      else         src = PC1_T[28 + ((p - 29 + tot) % 28)];
      res[47-o] = k[64-src];
    end
    return res;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one schedule on the default instance; call right after a negedge.
  task automatic run_main(input bit dec, input logic [63:0] k, input bit stall,
                          input bit inject, input logic exp_perr);
    int          exp_idx;
    int          got;
    int          dones;
    int          cyc;
    int          stall_run;
    bit          injected;
    bit          held;
    logic [47:0] prev_key;
    exp_idx   = dec ? 16 : 1;
    got       = 0;
    dones     = 0;
    cyc       = 0;
    stall_run = 0;
    injected  = 0;
    held      = 0;
    prev_key  = '0;
    start     = 1'b1;
    decrypt   = dec;
    key_in    = k;
    key_ready = 1'b1;
    @(negedge clk);
    while (cyc < 300) begin
      cyc++;
      start   = 1'b0;
      key_in  = k;
      decrypt = dec;
      if (done) begin
        dones++;
        break;
      end
      if (key_valid) begin
        chk("round_idx", 64'(round_idx), 64'(exp_idx));
        chk("key_out", 64'(key_out), 64'(ref_key(k, exp_idx, 16'h7EFC)));
        chk("busy_gen", 64'(busy), 64'd1);
        if (held) chk("stall_hold", 64'(key_out), 64'(prev_key));
        if (k == KEY_A && exp_idx == 1)  chk("k1_lit", 64'(key_out), 64'h1B02EFFC7072);
        if (k == KEY_A && exp_idx == 2)  chk("k2_lit", 64'(key_out), 64'h79AED9DBC9E5);
        if (k == KEY_A && exp_idx == 16) chk("k16_lit", 64'(key_out), 64'hCB3D8B0E17F5);
        if (stall) begin
          if (stall_run >= 5) key_ready = 1'b1;
          else                key_ready = ($urandom_range(0, 99) < 50);
          stall_run = key_ready ? 0 : stall_run + 1;
        end else begin
          key_ready = 1'b1;
        end
        if (inject && !injected && exp_idx == 5) begin
          start    = 1'b1;
          key_in   = 64'h0;
          decrypt  = ~dec;
          injected = 1;
        end
        prev_key = key_out;
        held     = !key_ready;
        if (key_ready) begin
          got++;
          exp_idx += dec ? -1 : 1;
        end
      end else begin
        chk("valid_gap", 64'(key_valid), 64'd1);
      end
      @(negedge clk);
    end
    chk("done_seen", 64'(dones), 64'd1);
    chk("key_count", 64'(got), 64'd16);
    if (!stall) chk("done_cycle", 64'(cyc), 64'd17);
    chk("idle_flags", {62'd0, busy, key_valid}, 64'd0);
    chk("parity_err", 64'(parity_err), 64'(exp_perr));
  endtask

  // Runs one schedule on the 4-round variant; call right after a negedge.
  task automatic run_var(input bit dec);
    int exp_idx;
    int got;
    int cyc;
    exp_idx     = dec ? 4 : 1;
    got         = 0;
    cyc         = 0;
    v_key_in    = KEY_A;
    v_decrypt   = dec;
    v_start     = 1'b1;
    @(negedge clk);
    v_start = 1'b0;
    while (cyc < 20) begin
      cyc++;
      if (v_done) break;
      if (v_key_valid) begin
        chk("v_round_idx", 64'(v_round_idx), 64'(exp_idx));
        chk("v_key_out", 64'(v_key_out), 64'(ref_key(KEY_A, exp_idx, 16'h0003)));
        got++;
        exp_idx += dec ? -1 : 1;
      end else begin
        chk("v_valid_gap", 64'(v_key_valid), 64'd1);
      end
      @(negedge clk);
    end
    chk("v_done_cycle", 64'(cyc), 64'd5);
    chk("v_key_count", 64'(got), 64'd4);
    chk("v_idle", {62'd0, v_busy, v_key_valid}, 64'd0);
  endtask

  initial begin
    int cyc;
    rst         = 1'b1;
    start       = 1'b0;
    decrypt     = 1'b0;
    key_in      = '0;
    key_ready   = 1'b1;
    v_start     = 1'b0;
    v_decrypt   = 1'b0;
    v_key_in    = '0;
    v_key_ready = 1'b1;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    chk("reset_outs", {5'd0, busy, key_valid, done, parity_err, round_idx, key_out}, 64'd0);
    chk("v_reset_outs", {5'd0, v_busy, v_key_valid, v_done, v_parity_err, v_round_idx, v_key_out}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Encrypt, no stalls; done must be a single-cycle pulse.
    run_main(1'b0, KEY_A, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("done_width", 64'(done), 64'd0);

    // Decrypt, no stalls: reverse order of the encrypt keys.
    run_main(1'b1, KEY_A, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // Backpressure in both directions.
    run_main(1'b0, KEY_A, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    run_main(1'b1, KEY_B, 1'b1, 1'b0, 1'b0);
    @(negedge clk);

    // Start while busy is ignored; then back-to-back start with a bad-parity key.
    run_main(1'b0, KEY_A, 1'b0, 1'b1, 1'b0);
    run_main(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);

    // Asynchronous reset in the middle of round 9.
    start   = 1'b1;
    decrypt = 1'b0;
    key_in  = KEY_A;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    while (cyc < 40 && round_idx != 5'd9) begin
      cyc++;
      @(negedge clk);
    end
    chk("reach_round9", 64'(round_idx), 64'd9);
    #2 rst = 1'b1;
    #1 chk("async_reset", {5'd0, busy, key_valid, done, parity_err, round_idx, key_out}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("no_done_after_rst", {62'd0, done, busy}, 64'd0);
    run_main(1'b0, KEY_A, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // Four-round variant, shifts 2,2,1,1.
    run_var(1'b0);
    @(negedge clk);
    run_var(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
